arbitro_rr: RTL and testbench

Parametrised successor of the four-channel fixed-priority arbiter between the source FIFOs (high class "naranja", low class "morado") and the destination FIFOs of the transaction layer. Each cycle it selects at most one source FIFO to pop, across `NUM_CH` channels and two traffic classes. Selection is strict class priority with per-class round-robin (or fixed priority), plus a burst limit. It stalls globally on any destination `almost_full` and emits a registered push strobe aligned with the popped data.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 55 +++++
 rtl/arbitro_rr.sv | 87 ++++++++
 tb/tb_arbitro_rr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and width helper for the round-robin transaction-layer arbiter.
package arb_pkg;
  localparam logic [3:0] ARB_IDLE_DEF = 4'b0001;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width with a floor of one bit so two-entry fields stay legal.
  function automatic int arb_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Per-class pick: wrap search from ptr for the first requester, plus burst bookkeeping.
module rr_pick import arb_pkg::*; #(
  parameter int NUM_CH    = 4,
  parameter int MODE      = ARB_RR,
  parameter int MAX_BURST = 2,
  parameter int CH_W      = arb_w(NUM_CH),
  parameter int CNT_W     = arb_w(MAX_BURST + 1)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic              vld,
  output logic [CH_W-1:0]   idx,
  output logic [CH_W-1:0]   ptr_nxt,
  output logic [CNT_W-1:0]  cnt_nxt
);
  int   j;
  int   c;
  logic found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    j       = 0;
    c       = 0;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    for (int i = 0; i < NUM_CH; i++) begin
      j = (int'(ptr) + i) % NUM_CH;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = CH_W'(j);
      end
    end
    vld = en & found;
    if (vld) gnt[idx] = 1'b1;
    // Staying on the pointed channel extends the burst; moving elsewhere starts a new one.
    c = (idx == ptr) ? int'(cnt) + 1 : 1;
    if (MODE == ARB_RR) begin
      if (c >= MAX_BURST) begin
        ptr_nxt = CH_W'((int'(idx) + 1) % NUM_CH);
        cnt_nxt = '0;
      end else begin
        ptr_nxt = idx;
        cnt_nxt = CNT_W'(c);
      end
    end else begin
      ptr_nxt = '0;
      cnt_nxt = '0;
    end
  end
endmodule

// File: rtl/arbitro_rr.sv
// Two-class source-FIFO pop arbiter with stall gating and a one-cycle push pipeline.
module arbitro_rr import arb_pkg::*; #(
  parameter int          NUM_CH     = 4,
  parameter int          MODE       = ARB_RR,
  parameter int          MAX_BURST  = 2,
  parameter logic [3:0]  IDLE_STATE = ARB_IDLE_DEF,
  localparam int         CH_W       = arb_w(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic [3:0]          state,
  input  logic [NUM_CH-1:0]   almost_full,
  input  logic [NUM_CH-1:0]   empty_hi,
  input  logic [NUM_CH-1:0]   empty_lo,
  output logic [NUM_CH-1:0]   pop_hi,
  output logic [NUM_CH-1:0]   pop_lo,
  output logic                push,
  output logic [CH_W-1:0]     push_sel,
  output logic                push_cls,
  output logic [2*NUM_CH-1:0] empties
);
  localparam int CNT_W = arb_w(MAX_BURST + 1);

  // Class index 1 = high (naranja), 0 = low (morado).
  logic [1:0][NUM_CH-1:0] req, gnt;
  logic [1:0][CH_W-1:0]   ptr_q, ptr_nxt, idx;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [1:0]             en, vld;
  logic                   idle, blocked;

  assign idle    = (state == IDLE_STATE);
  assign blocked = !reset_L || idle || (|almost_full);
  assign req[1]  = ~empty_hi;
  assign req[0]  = ~empty_lo;
  assign en[1]   = !blocked;
  assign en[0]   = !blocked && !(|req[1]);

  for (genvar k = 0; k < 2; k++) begin : g_cls
    rr_pick #(
      .NUM_CH(NUM_CH), .MODE(MODE), .MAX_BURST(MAX_BURST), .CH_W(CH_W), .CNT_W(CNT_W)
    ) u_pick (
      .req(req[k]), .ptr(ptr_q[k]), .cnt(cnt_q[k]), .en(en[k]),
      .gnt(gnt[k]), .vld(vld[k]), .idx(idx[k]),
      .ptr_nxt(ptr_nxt[k]), .cnt_nxt(cnt_nxt[k])
    );
  end

  assign pop_hi = gnt[1];
  assign pop_lo = gnt[0];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (idle) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (vld[k]) begin
          ptr_q[k] <= ptr_nxt[k];
          cnt_q[k] <= cnt_nxt[k];
        end
      end
    end
  end

  // Push lines up with the source FIFO's registered read data.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push     <= 1'b0;
      push_sel <= '0;
      push_cls <= 1'b0;
      empties  <= '0;
    end else begin
      push <= |vld;
      if (vld[1]) begin
        push_sel <= idx[1];
        push_cls <= 1'b1;
      end else if (vld[0]) begin
        push_sel <= idx[0];
        push_cls <= 1'b0;
      end
      empties <= idle ? '0 : {empty_lo, empty_hi};
    end
  end
endmodule

// File: tb/tb_arbitro_rr.sv
// Directed table-driven bench for arbitro_rr (RR instance) plus a fixed-priority instance.
module tb_arbitro_rr;
  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] ACT  = 4'b0100;

  logic       clk;
  logic       reset_L, rst0;
  logic [3:0] state, af, ehi, elo;
  logic [3:0] pop_hi, pop_lo;
  logic       push, push_cls;
  logic [1:0] push_sel;
  logic [7:0] empties;

  logic [3:0] state0, af0, ehi0, elo0;
  logic [3:0] pop_hi0, pop_lo0;
  logic       push0, push_cls0;
  logic [1:0] push_sel0;
  logic [7:0] empties0;

  int checks   = 0;
  int failures = 0;

  logic       m_push, m_cls;
  logic [1:0] m_sel;
  logic [7:0] m_emp;

  arbitro_rr #(.NUM_CH(4), .MODE(1), .MAX_BURST(2)) dut (
    .clk(clk), .reset_L(reset_L), .state(state), .almost_full(af),
    .empty_hi(ehi), .empty_lo(elo), .pop_hi(pop_hi), .pop_lo(pop_lo),
    .push(push), .push_sel(push_sel), .push_cls(push_cls), .empties(empties)
  );

  arbitro_rr #(.NUM_CH(4), .MODE(0), .MAX_BURST(2)) dut0 (
    .clk(clk), .reset_L(rst0), .state(state0), .almost_full(af0),
    .empty_hi(ehi0), .empty_lo(elo0), .pop_hi(pop_hi0), .pop_lo(pop_lo0),
    .push(push0), .push_sel(push_sel0), .push_cls(push_cls0), .empties(empties0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st, af, ehi, elo, xhi, xlo;
  } vec_t;

  vec_t vec[$];

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, n, act, exp);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // One cycle on the RR instance: called at a negedge, checks just before the posedge.
  task automatic cyc(input vec_t v, input int n);
    state = v.st; af = v.af; ehi = v.ehi; elo = v.elo;
    #4;
    chk("pop_hi", n, 32'(pop_hi), 32'(v.xhi));
    chk("pop_lo", n, 32'(pop_lo), 32'(v.xlo));
    chk("push", n, 32'(push), 32'(m_push));
    if (m_push) begin
      chk("push_sel", n, 32'(push_sel), 32'(m_sel));
      chk("push_cls", n, 32'(push_cls), 32'(m_cls));
    end
    chk("empties", n, 32'(empties), 32'(m_emp));
    m_push = (v.xhi != 4'd0) || (v.xlo != 4'd0);
    if (v.xhi != 4'd0) begin
      m_sel = oh_idx(v.xhi); m_cls = 1'b1;
    end else if (v.xlo != 4'd0) begin
      m_sel = oh_idx(v.xlo); m_cls = 1'b0;
    end
    m_emp = (v.st == IDLE) ? 8'd0 : {v.elo, v.ehi};
    @(negedge clk);
  endtask

  initial begin
    reset_L = 1'b0; rst0 = 1'b0;
    state = ACT; af = 4'd0; ehi = 4'd0; elo = 4'd0;
    state0 = ACT; af0 = 4'd0; ehi0 = 4'd0; elo0 = 4'd0;
    m_push = 1'b0; m_cls = 1'b0; m_sel = 2'd0; m_emp = 8'd0;
    #2;
    chk("rst_pop_hi", 0, 32'(pop_hi), 32'd0);
    chk("rst_pop_lo", 0, 32'(pop_lo), 32'd0);
    chk("rst_push", 0, 32'(push), 32'd0);
    chk("rst_sel", 0, 32'(push_sel), 32'd0);
    chk("rst_cls", 0, 32'(push_cls), 32'd0);
    chk("rst_empties", 0, 32'(empties), 32'd0);
    @(negedge clk);
    reset_L = 1'b1; rst0 = 1'b1;

    // idle with everything non-empty
    vec.push_back({IDLE, 4'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vec.push_back({IDLE, 4'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    // high class rotation, burst of 2
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0010, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0010, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0100, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0100, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b1000, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b1000, 4'b0000});
    // wrap search skips empty channels 1 and 3
    vec.push_back({ACT, 4'h0, 4'b1010, 4'b1111, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1010, 4'b1111, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1010, 4'b1111, 4'b0100, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1010, 4'b1111, 4'b0100, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1010, 4'b1111, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1010, 4'b1111, 4'b0001, 4'b0000});
    // almost_full stall mid-burst on ch1; burst resumes with one grant left
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0010, 4'b0000});
    vec.push_back({ACT, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vec.push_back({ACT, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vec.push_back({ACT, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0010, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0100, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b1111, 4'b0100, 4'b0000});
    // low class, then high preemption mid-burst; low cnt preserved
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0110, 4'b0000, 4'b0001});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0110, 4'b0000, 4'b0001});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0110, 4'b0000, 4'b1000});
    vec.push_back({ACT, 4'h0, 4'b1011, 4'b0110, 4'b0100, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0110, 4'b0000, 4'b1000});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0110, 4'b0000, 4'b0001});
    // all empty: nothing popped, low ptr/cnt hold
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b1111, 4'b0000, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b1111, 4'b0000, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0000, 4'b0000, 4'b0001});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0000, 4'b0000, 4'b0010});
    // idle clears both pointers
    vec.push_back({IDLE, 4'h0, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b1111, 4'b0000, 4'b0000, 4'b0001});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
    vec.push_back({ACT, 4'h0, 4'b0000, 4'b0000, 4'b0010, 4'b0000});

    foreach (vec[i]) cyc(vec[i], i);

    // asynchronous reset mid-burst on ch1
    reset_L = 1'b0;
    #1;
    chk("mid_rst_pop_hi", 0, 32'(pop_hi), 32'd0);
    chk("mid_rst_pop_lo", 0, 32'(pop_lo), 32'd0);
    chk("mid_rst_push", 0, 32'(push), 32'd0);
    chk("mid_rst_sel", 0, 32'(push_sel), 32'd0);
    chk("mid_rst_empties", 0, 32'(empties), 32'd0);
    m_push = 1'b0; m_sel = 2'd0; m_cls = 1'b0; m_emp = 8'd0;
    @(negedge clk);
    reset_L = 1'b1;
    cyc({ACT, 4'h0, 4'b0000, 4'b0000, 4'b0001, 4'b0000}, 100);
    cyc({ACT, 4'h0, 4'b0000, 4'b0000, 4'b0001, 4'b0000}, 101);
    cyc({ACT, 4'h0, 4'b0000, 4'b0000, 4'b0010, 4'b0000}, 102);

    // fixed-priority instance: ch0 every cycle, no rotation
    for (int k = 0; k < 4; k++) begin
      #4;
      chk("fx_pop_hi", k, 32'(pop_hi0), 32'b0001);
      chk("fx_pop_lo", k, 32'(pop_lo0), 32'd0);
      chk("fx_push", k, 32'(push0), 32'd1);
      chk("fx_sel", k, 32'(push_sel0), 32'd0);
      chk("fx_cls", k, 32'(push_cls0), 32'd1);
      @(negedge clk);
    end
    rst0 = 1'b0;
    #1;
    chk("fx_rst_pop_hi", 0, 32'(pop_hi0), 32'd0);
    chk("fx_rst_push", 0, 32'(push0), 32'd0);
    chk("fx_rst_cls", 0, 32'(push_cls0), 32'd0);
    chk("fx_rst_empties", 0, 32'(empties0), 32'd0);
    @(negedge clk);
    rst0 = 1'b1;
    #4;
    chk("fx_rel_pop_hi", 0, 32'(pop_hi0), 32'b0001);
    chk("fx_rel_push", 0, 32'(push0), 32'd0);
    @(negedge clk);
    #4;
    chk("fx_rel_push", 1, 32'(push0), 32'd1);
    chk("fx_rel_sel", 1, 32'(push_sel0), 32'd0);
    chk("fx_rel_empties", 1, 32'(empties0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
